core_sram_arb: RTL

Two-requester arbiter that shares one single-port core SRAM macro between the RISC-V core data port and the Wishbone host path. It sits between the Wishbone-to-core-SRAM splitter output for one bank and that bank's SRAM macro. It replaces the direct core-to-SRAM connection, so firmware can be loaded and inspected over Wishbone while the core runs. Arbitration is round-robin under contention. Both sides see fixed one-cycle access latency.

---
 rtl/core_sram_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/core_sram_arb.sv
// Round-robin arbiter sharing one single-port core SRAM bank between the core
// data port (OBI-style) and the Wishbone host path, with fixed one-cycle latency.
module core_sram_arb #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          core_req_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic          core_we_i,
    input  logic [3:0]    core_be_i,
    input  logic [31:0]   core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [31:0]   core_rdata_o,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_wdata_i,
    output logic          wb_ack_o,
    output logic [31:0]   wb_rdata_o,
    output logic          sram_csb_o,
    output logic          sram_web_o,
    output logic [3:0]    sram_wmask_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_din_o,
    input  logic [31:0]   sram_dout_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_WB   = 2'd2
    } owner_e;

    owner_e resp_owner_q, resp_owner_d;
    logic   wb_pend_q, wb_pend_d;
    logic   last_wb_q, last_wb_d;   // 1: WB was granted most recently
    logic   core_elig, wb_elig;
    logic   core_win, wb_win;

    // Issue is suppressed while reset is held so the macro never sees a stray access.
    always_comb begin
        core_elig = core_req_i;
        wb_elig   = wb_cyc_i & wb_stb_i & ~wb_pend_q;
        core_win  = 1'b0;
        wb_win    = 1'b0;
        if (rst_ni) begin
            if (core_elig && wb_elig) begin
                core_win = last_wb_q;
                wb_win   = ~last_wb_q;
            end else begin
                core_win = core_elig;
                wb_win   = wb_elig;
            end
        end
    end

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = 4'h0;
        sram_addr_o  = '0;
        sram_din_o   = 32'h0;
        core_gnt_o   = 1'b0;
        if (core_win) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~core_we_i;
            sram_wmask_o = core_be_i;
            sram_addr_o  = core_addr_i;
            sram_din_o   = core_wdata_i;
            core_gnt_o   = 1'b1;
        end else if (wb_win) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~wb_we_i;
            sram_wmask_o = wb_sel_i;
            sram_addr_o  = wb_addr_i;
            sram_din_o   = wb_wdata_i;
        end
    end

    always_comb begin
        core_rvalid_o = 1'b0;
        core_rdata_o  = 32'h0;
        wb_ack_o      = 1'b0;
        wb_rdata_o    = 32'h0;
        if (resp_owner_q == OWN_CORE) begin
            core_rvalid_o = 1'b1;
            core_rdata_o  = sram_dout_i;
        end else if (resp_owner_q == OWN_WB) begin
            wb_ack_o   = 1'b1;
            wb_rdata_o = sram_dout_i;
        end
    end

    always_comb begin
        resp_owner_d = OWN_NONE;
        wb_pend_d    = wb_pend_q;
        last_wb_d    = last_wb_q;
        if (resp_owner_q == OWN_WB) begin
            wb_pend_d = 1'b0;
        end
        if (core_win) begin
            resp_owner_d = OWN_CORE;
            last_wb_d    = 1'b0;
        end else if (wb_win) begin
            resp_owner_d = OWN_WB;
            wb_pend_d    = 1'b1;
            last_wb_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_owner_q <= OWN_NONE;
            wb_pend_q    <= 1'b0;
            last_wb_q    <= 1'b1;
        end else begin
            resp_owner_q <= resp_owner_d;
            wb_pend_q    <= wb_pend_d;
            last_wb_q    <= last_wb_d;
        end
    end

endmodule
